// File: rtl/uvma_mpb_arbiter_if.sv
// MPB arbiter bundle: requester-side and target-side signals.
// master = arbiter view, slave = surrounding masters/target view.
interface uvma_mpb_arbiter_if #(
    parameter int NUM_MSTR   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_MSTR-1:0]            m_vld;
    logic [NUM_MSTR-1:0]            m_rdy;
    logic [NUM_MSTR-1:0]            m_wr;
    logic [NUM_MSTR*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MSTR*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MSTR-1:0]            m_ack;
    logic [DATA_WIDTH-1:0]          m_rdata;
    logic                           m_err;
    logic                           s_vld;
    logic                           s_rdy;
    logic                           s_wr;
    logic [ADDR_WIDTH-1:0]          s_addr;
    logic [DATA_WIDTH-1:0]          s_wdata;
    logic                           s_ack;
    logic [DATA_WIDTH-1:0]          s_rdata;
    logic                           s_err;

    modport master (
        input  m_vld, m_wr, m_addr, m_wdata,
        input  s_rdy, s_ack, s_rdata, s_err,
        output m_rdy, m_ack, m_rdata, m_err,
        output s_vld, s_wr, s_addr, s_wdata
    );

    modport slave (
        output m_vld, m_wr, m_addr, m_wdata,
        output s_rdy, s_ack, s_rdata, s_err,
        input  m_rdy, m_ack, m_rdata, m_err,
        input  s_vld, s_wr, s_addr, s_wdata
    );
endinterface

// File: rtl/uvma_mpb_arbiter.sv
// Round-robin MPB arbiter: one outstanding transaction replayed
// from the granted master onto a single target port, with timeout.
module uvma_mpb_arbiter #(
    parameter int NUM_MSTR       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IW = $clog2(NUM_MSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    uvma_mpb_arbiter_if.master    bus,
    output logic [IW-1:0]         grant_idx,
    output logic                  busy,
    output logic                  timeout_evt
);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_M1 = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t                r_state, w_nxt;
    logic [IW-1:0]         r_ptr, r_gidx;
    logic [CW-1:0]         r_cnt;
    logic                  r_s_wr;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [DATA_WIDTH-1:0] r_s_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_any;
    logic [IW-1:0]         w_gnt;
    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_ack_acc;
    logic                  w_to;
    logic                  w_waiting;
    logic [NUM_MSTR-1:0]   w_m_rdy;
    logic [NUM_MSTR-1:0]   w_m_ack;
    logic                  w_s_vld;
    logic                  w_busy;
    logic                  w_to_evt;

    // First requester at or after the pointer, wrapping around
    always_comb begin
        int j;
        w_any       = 1'b0;
        w_gnt       = '0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_MSTR; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_MSTR) j = j - NUM_MSTR;
            if (!w_any && bus.m_vld[j]) begin
                w_any       = 1'b1;
                w_gnt       = IW'(j);
                w_sel_wr    = bus.m_wr[j];
                w_sel_addr  = bus.m_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.m_wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_waiting = (r_state == REQ) || (r_state == RSP);
    assign w_ack_acc = bus.s_ack &&
                       ((r_state == RSP) ||
                        ((r_state == REQ) && bus.s_rdy));
    assign w_to      = TO_EN && w_waiting && !w_ack_acc &&
                       (r_cnt == CW'(TO_M1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt    = r_state;
        w_m_rdy  = '0;
        w_m_ack  = '0;
        w_s_vld  = 1'b0;
        w_busy   = 1'b1;
        w_to_evt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_any && !reset) begin
                    w_m_rdy[w_gnt] = 1'b1;
                    w_nxt          = REQ;
                end
            end
            REQ: begin
                w_s_vld  = 1'b1;
                w_to_evt = w_to;
                if (w_ack_acc || w_to) w_nxt = DONE;
                else if (bus.s_rdy)    w_nxt = RSP;
            end
            RSP: begin
                w_to_evt = w_to;
                if (w_ack_acc || w_to) w_nxt = DONE;
            end
            DONE: begin
                w_m_ack[r_gidx] = 1'b1;
                w_nxt           = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_cnt     <= '0;
            r_s_wr    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_s_wr    <= w_sel_wr;
                r_s_addr  <= w_sel_addr;
                r_s_wdata <= w_sel_wdata;
                r_gidx    <= w_gnt;
                r_ptr     <= (w_gnt == IW'(NUM_MSTR - 1)) ?
                             '0 : w_gnt + 1'b1;
                r_cnt     <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ack_acc) begin
                r_rdata <= bus.s_rdata;
                r_err   <= bus.s_err;
            end else if (w_to) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.m_rdy   = w_m_rdy;
    assign bus.m_ack   = w_m_ack;
    assign bus.m_rdata = r_rdata;
    assign bus.m_err   = r_err;
    assign bus.s_vld   = w_s_vld;
    assign bus.s_wr    = r_s_wr;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign grant_idx   = r_gidx;
    assign busy        = w_busy;
    assign timeout_evt = w_to_evt;
endmodule

// File: tb/tb_uvma_mpb_arbiter.sv
// Directed self-checking bench for uvma_mpb_arbiter.
// Inputs change on negedge; outputs sampled 1ns after negedge.
module tb_uvma_mpb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout_evt;
    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         hs_cnt   = 0;

    uvma_mpb_arbiter_if #(.NUM_MSTR(N), .DATA_WIDTH(DW),
                          .ADDR_WIDTH(AW)) bus ();

    uvma_mpb_arbiter #(
        .NUM_MSTR(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_idx(grant_idx), .busy(busy),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.s_vld && bus.s_rdy) hs_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic idle_inputs();
        bus.m_vld   = '0;
        bus.m_wr    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_rdy   = 1'b0;
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        bus.s_err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.m_vld = 4'b1111;
        @(negedge clk); #1;
        chk("rst_m_rdy", 32'(bus.m_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_vld", 32'(bus.s_vld), 0);
        chk("rst_s_addr", bus.s_addr, 0);
        chk("rst_grant", 32'(grant_idx), 0);
        chk("rst_m_ack", 32'(bus.m_ack), 0);
        chk("rst_rdata", bus.m_rdata, 0);
        chk("rst_err", 32'(bus.m_err), 0);
        chk("rst_to", 32'(timeout_evt), 0);
        bus.m_vld = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.m_vld = 4'b0100;
        bus.m_wr  = 4'b0100;
        bus.m_addr[2*AW +: AW]  = 32'h10;
        bus.m_wdata[2*DW +: DW] = 32'hDEADBEEF;
        bus.s_rdy = 1'b1;
        #1 chk("sw_m_rdy", 32'(bus.m_rdy), 32'h4);
        @(negedge clk);
        bus.m_vld = '0;
        #1;
        chk("sw_s_vld", 32'(bus.s_vld), 1);
        chk("sw_s_addr", bus.s_addr, 32'h10);
        chk("sw_s_wdata", bus.s_wdata, 32'hDEADBEEF);
        chk("sw_s_wr", 32'(bus.s_wr), 1);
        chk("sw_grant", 32'(grant_idx), 2);
        @(negedge clk); #1;
        chk("sw_rsp_svld", 32'(bus.s_vld), 0);
        chk("sw_rsp_busy", 32'(busy), 1);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'hCAFE;
        @(negedge clk);
        bus.s_ack = 1'b0;
        bus.s_rdy = 1'b0;
        #1 chk("sw_m_ack", 32'(bus.m_ack), 32'h4);
        @(negedge clk); #1;
        chk("sw_ack_gone", 32'(bus.m_ack), 0);
        chk("sw_idle", 32'(busy), 0);
    endtask

    task automatic test_ack_on_hs();
        @(negedge clk);
        bus.m_vld = 4'b0010;
        bus.m_wr  = '0;
        bus.m_addr[1*AW +: AW] = 32'h20;
        bus.s_rdy = 1'b1;
        #1 chk("hs_m_rdy", 32'(bus.m_rdy), 32'h2);
        @(negedge clk);
        bus.m_vld   = '0;
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'h1234;
        bus.s_err   = 1'b0;
        #1;
        chk("hs_grant", 32'(grant_idx), 1);
        chk("hs_s_wr", 32'(bus.s_wr), 0);
        @(negedge clk);
        bus.s_ack   = 1'b0;
        bus.s_rdy   = 1'b0;
        bus.s_rdata = '0;
        #1;
        chk("hs_m_ack", 32'(bus.m_ack), 32'h2);
        chk("hs_rdata", bus.m_rdata, 32'h1234);
        chk("hs_err", 32'(bus.m_err), 0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int h0;
        int stable;
        stable = 1;
        @(negedge clk);
        bus.m_vld = 4'b0001;
        bus.m_wr  = 4'b0001;
        bus.m_addr[0 +: AW]  = 32'h30;
        bus.m_wdata[0 +: DW] = 32'hA5A5A5A5;
        bus.s_rdy = 1'b0;
        h0 = hs_cnt;
        #1 chk("bp_m_rdy", 32'(bus.m_rdy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.m_vld = '0;
            #1;
            if (bus.s_vld !== 1'b1 || bus.s_addr !== 32'h30 ||
                bus.s_wdata !== 32'hA5A5A5A5)
                stable = 0;
            if (i == 5) bus.s_rdy = 1'b1;
        end
        chk("bp_stable", 32'(stable), 1);
        @(negedge clk);
        bus.s_rdy = 1'b0;
        #1;
        chk("bp_rsp_svld", 32'(bus.s_vld), 0);
        chk("bp_one_hs", 32'(hs_cnt - h0), 1);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'h5555;
        @(negedge clk);
        bus.s_ack = 1'b0;
        #1;
        chk("bp_m_ack", 32'(bus.m_ack), 32'h1);
        chk("bp_rdata", bus.m_rdata, 32'h5555);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int first_to;
        first_to = -1;
        @(negedge clk);
        bus.m_vld = 4'b1000;
        bus.m_addr[3*AW +: AW] = 32'h77;
        bus.s_rdy = 1'b1;
        #1 chk("to_m_rdy", 32'(bus.m_rdy), 32'h8);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus.m_vld = '0;
            #1;
            if (timeout_evt === 1'b1 && first_to < 0) first_to = k;
        end
        chk("to_evt_cycle", 32'(first_to), 16);
        @(negedge clk); #1;
        chk("to_m_ack", 32'(bus.m_ack), 32'h8);
        chk("to_err", 32'(bus.m_err), 1);
        chk("to_rdata", bus.m_rdata, 0);
        chk("to_evt_pulse", 32'(timeout_evt), 0);
        @(negedge clk);
        bus.s_rdy   = 1'b0;
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'hFFFF;
        @(negedge clk);
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        #1;
        chk("late_ack_m_ack", 32'(bus.m_ack), 0);
        chk("late_ack_busy", 32'(busy), 0);
        chk("late_ack_rdata", bus.m_rdata, 0);
    endtask

    task automatic test_reset_mid_rsp();
        @(negedge clk);
        bus.m_vld = 4'b0010;
        bus.m_wr  = 4'b0010;
        bus.m_addr[1*AW +: AW] = 32'h40;
        bus.s_rdy = 1'b1;
        @(negedge clk);
        bus.m_vld = '0;
        @(negedge clk);
        bus.s_rdy = 1'b0;
        #1 chk("mr_busy_rsp", 32'(busy), 1);
        reset     = 1'b1;
        bus.s_ack = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_s_addr", bus.s_addr, 0);
        chk("mr_s_wr", 32'(bus.s_wr), 0);
        chk("mr_grant", 32'(grant_idx), 0);
        chk("mr_err", 32'(bus.m_err), 0);
        @(negedge clk); #1;
        chk("mr_no_ack", 32'(bus.m_ack), 0);
        bus.s_ack = 1'b0;
        reset     = 1'b0;
        bus.m_vld = 4'b1111;
        #1 chk("mr_first_m0", 32'(bus.m_rdy), 32'h1);
        @(negedge clk);
        bus.m_vld = '0;
        bus.s_rdy = 1'b1;
        bus.s_ack = 1'b1;
        @(negedge clk);
        bus.s_rdy = 1'b0;
        bus.s_ack = 1'b0;
        #1 chk("mr_m_ack", 32'(bus.m_ack), 32'h1);
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++)
            bus.m_addr[i*AW +: AW] = 32'h100 + 32'(i);
        bus.m_vld = 4'b1111;
        bus.s_rdy = 1'b1;
        bus.s_ack = 1'b1;
        for (int t = 0; t < 8; t++) begin
            e = 4'(1 << (t % N));
            #1 chk("rr_m_rdy", 32'(bus.m_rdy), 32'(e));
            @(negedge clk); #1;
            chk("rr_grant", 32'(grant_idx), 32'(t % N));
            chk("rr_s_addr", bus.s_addr, 32'h100 + 32'(t % N));
            @(negedge clk); #1;
            chk("rr_m_ack", 32'(bus.m_ack), 32'(e));
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_ack_on_hs();
        test_backpressure();
        test_timeout();
        test_reset_mid_rsp();
        test_round_robin();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
